mem_arbiter: RTL and testbench

MEM_ARBITER -- requirements
Module: mem_arbiter

---
 rtl/mem_arb_pkg.sv | 14 +
 rtl/rr_arbiter.sv | 18 +
 rtl/mem_arbiter.sv | 126 ++++++++++++
 tb/tb_mem_arbiter.sv | 223 ++++++++++++++++++++++
 4 files changed

// File: rtl/mem_arb_pkg.sv
// Shared types for the two-port line-transfer memory arbiter.
package mem_arb_pkg;

    localparam int unsigned LINE_WORDS_DEF = 4;

    typedef enum logic [1:0] {
        StIdle,
        StBurst,
        StDone
    } state_e;

    typedef logic [LINE_WORDS_DEF-1:0][31:0] line_t;

endpackage

// File: rtl/rr_arbiter.sv
// Two-requester round-robin pick; last_i = 1 means port 1 was served most recently.
module rr_arbiter (
    input  logic [1:0] req_i,
    input  logic       last_i,
    output logic [1:0] gnt_o
);

    always_comb begin
        gnt_o = 2'b00;
        case (req_i)
            2'b01:   gnt_o = 2'b01;
            2'b10:   gnt_o = 2'b10;
            2'b11:   gnt_o = last_i ? 2'b01 : 2'b10;
            default: gnt_o = 2'b00;
        endcase
    end

endmodule

// File: rtl/mem_arbiter.sv
// Arbitrates icache/dcache line transfers onto a single-beat memory port,
// moving one word per accepted beat and signalling completion with a done pulse.
module mem_arbiter
    import mem_arb_pkg::*;
#(
    parameter int unsigned LINE_WORDS = LINE_WORDS_DEF,
    parameter int unsigned ADDR_W     = 32
) (
    input  logic                     clk_i,
    input  logic                     rst_i,
    input  logic                     req0_i,
    input  logic                     req1_i,
    input  logic [ADDR_W-1:0]        addr0_i,
    input  logic [ADDR_W-1:0]        addr1_i,
    input  logic                     we0_i,
    input  logic                     we1_i,
    input  logic [LINE_WORDS*32-1:0] wdata0_i,
    input  logic [LINE_WORDS*32-1:0] wdata1_i,
    output logic                     gnt0_o,
    output logic                     gnt1_o,
    output logic                     done0_o,
    output logic                     done1_o,
    output logic [LINE_WORDS*32-1:0] rdata_o,
    output logic [ADDR_W-1:0]        mem_addr_o,
    output logic [31:0]              mem_dataW_o,
    output logic                     mem_MemRW_o,
    output logic                     mem_req_valid_o,
    input  logic [31:0]              mem_dataR_i,
    input  logic                     mem_valid_i
);

    localparam int unsigned BeatW = $clog2(LINE_WORDS);
    localparam logic [ADDR_W-1:0] BaseMask = ~ADDR_W'(LINE_WORDS - 1);

    state_e                      state_q, state_d;
    logic                        port_q, port_d;
    logic                        last_q, last_d;
    logic                        we_q, we_d;
    logic [ADDR_W-1:0]           addr_q, addr_d;
    logic [BeatW-1:0]            beat_q, beat_d;
    logic [LINE_WORDS-1:0][31:0] line_q, line_d;
    logic [1:0]                  rr_gnt;

    rr_arbiter u_rr (
        .req_i  ({req1_i, req0_i}),
        .last_i (last_q),
        .gnt_o  (rr_gnt)
    );

    always_comb begin
        state_d         = state_q;
        port_d          = port_q;
        last_d          = last_q;
        we_d            = we_q;
        addr_d          = addr_q;
        beat_d          = beat_q;
        line_d          = line_q;
        done0_o         = 1'b0;
        done1_o         = 1'b0;
        mem_req_valid_o = 1'b0;
        mem_addr_o      = '0;
        mem_dataW_o     = '0;
        mem_MemRW_o     = 1'b0;

        case (state_q)
            StIdle: begin
                if (|rr_gnt) begin
                    port_d  = rr_gnt[1];
                    we_d    = rr_gnt[1] ? we1_i : we0_i;
                    addr_d  = (rr_gnt[1] ? addr1_i : addr0_i) & BaseMask;
                    line_d  = rr_gnt[1] ? wdata1_i : wdata0_i;
                    beat_d  = '0;
                    state_d = StBurst;
                end
            end
            StBurst: begin
                mem_req_valid_o = 1'b1;
                // Base is line-aligned, so OR-ing the beat index cannot carry upward.
                mem_addr_o      = addr_q | ADDR_W'(beat_q);
                mem_MemRW_o     = we_q;
                mem_dataW_o     = line_q[beat_q];
                if (mem_valid_i) begin
                    if (!we_q) begin
                        line_d[beat_q] = mem_dataR_i;
                    end
                    beat_d = beat_q + BeatW'(1);
                    if (beat_q == BeatW'(LINE_WORDS - 1)) begin
                        state_d = StDone;
                    end
                end
            end
            StDone: begin
                done0_o = !port_q;
                done1_o = port_q;
                last_d  = port_q;
                state_d = StIdle;
            end
            default: state_d = StIdle;
        endcase

        gnt0_o  = (state_q != StIdle) && !port_q;
        gnt1_o  = (state_q != StIdle) && port_q;
        rdata_o = line_q;
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_q <= StIdle;
            port_q  <= 1'b0;
            last_q  <= 1'b1;
            we_q    <= 1'b0;
            addr_q  <= '0;
            beat_q  <= '0;
            line_q  <= '0;
        end else begin
            state_q <= state_d;
            port_q  <= port_d;
            last_q  <= last_d;
            we_q    <= we_d;
            addr_q  <= addr_d;
            beat_q  <= beat_d;
            line_q  <= line_d;
        end
    end

endmodule

// File: tb/tb_mem_arbiter.sv
// Directed bench for mem_arbiter with a transaction-level reference model.
module tb_mem_arbiter;

    localparam int unsigned LW = 4;
    localparam int unsigned AW = 32;

    logic            clk = 1'b0;
    logic            rst;
    logic            req0, req1, we0, we1;
    logic [AW-1:0]   addr0, addr1;
    logic [LW*32-1:0] wdata0, wdata1;
    logic            gnt0, gnt1, done0, done1;
    logic [LW*32-1:0] rdata;
    logic [AW-1:0]   mem_addr;
    logic [31:0]     mem_dataW, mem_dataR;
    logic            mem_rw, mem_req_valid, mem_valid;

    always #5 clk = ~clk;

    mem_arbiter #(
        .LINE_WORDS (LW),
        .ADDR_W     (AW)
    ) dut (
        .clk_i           (clk),
        .rst_i           (rst),
        .req0_i          (req0),
        .req1_i          (req1),
        .addr0_i         (addr0),
        .addr1_i         (addr1),
        .we0_i           (we0),
        .we1_i           (we1),
        .wdata0_i        (wdata0),
        .wdata1_i        (wdata1),
        .gnt0_o          (gnt0),
        .gnt1_o          (gnt1),
        .done0_o         (done0),
        .done1_o         (done1),
        .rdata_o         (rdata),
        .mem_addr_o      (mem_addr),
        .mem_dataW_o     (mem_dataW),
        .mem_MemRW_o     (mem_rw),
        .mem_req_valid_o (mem_req_valid),
        .mem_dataR_i     (mem_dataR),
        .mem_valid_i     (mem_valid)
    );

    // Simple word memory behind the arbiter.
    logic [31:0] mem [256];
    assign mem_dataR = mem[mem_addr[7:0]];
    always @(posedge clk) begin
        if (mem_req_valid && mem_valid && mem_rw) mem[mem_addr[7:0]] <= mem_dataW;
    end

    int n_checks = 0;
    int n_pass   = 0;
    bit chk_en   = 1'b0;
    logic [AW-1:0] addr_log [48];

    task automatic check(input string name, input logic [127:0] act, input logic [127:0] exp);
        n_checks++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %h expected %h (t=%0t)", name, act, exp, $time);
    endtask

    // Reference model: one transfer at a time, tracked as a count of beats moved.
    bit          m_active, m_done, m_port, m_last, m_we, m_rvalid;
    int          m_cnt;
    logic [31:0] m_base;
    logic [31:0] m_wline [LW];
    logic [31:0] m_rline [LW];

    initial forever begin
        @(posedge clk);
        if (rst) begin
            m_active = 0; m_done = 0; m_cnt = 0; m_last = 1; m_port = 0;
            m_we = 0; m_base = 0; m_rvalid = 1;
            for (int k = 0; k < LW; k++) begin m_rline[k] = 0; m_wline[k] = 0; end
        end else if (m_done) begin
            m_done = 0;
            m_last = m_port;
        end else if (m_active) begin
            if (mem_valid) begin
                if (!m_we) m_rline[m_cnt] = mem[(m_base + 32'(m_cnt)) % 256];
                m_cnt++;
                if (m_cnt == LW) begin
                    m_active = 0;
                    m_done   = 1;
                    m_rvalid = !m_we;
                end
            end
        end else if (req0 || req1) begin
            m_port   = (req0 && req1) ? !m_last : req1;
            m_base   = (m_port ? addr1 : addr0) / LW * LW;
            m_we     = m_port ? we1 : we0;
            for (int k = 0; k < LW; k++)
                m_wline[k] = m_port ? wdata1[32*k +: 32] : wdata0[32*k +: 32];
            m_active = 1;
            m_cnt    = 0;
            m_rvalid = 0;
        end
    end

    // Cycle-by-cycle comparison of every output against the model.
    initial forever begin
        @(negedge clk);
        if (chk_en) begin
            logic [LW*32-1:0] exp_line;
            for (int k = 0; k < LW; k++) exp_line[32*k +: 32] = m_rline[k];
            check("mem_req_valid", 128'(mem_req_valid), 128'(m_active));
            check("mem_addr", 128'(mem_addr), m_active ? 128'(m_base + 32'(m_cnt)) : 128'(0));
            check("mem_MemRW", 128'(mem_rw), 128'(m_active && m_we));
            check("mem_dataW", 128'(mem_dataW), m_active ? 128'(m_wline[m_cnt]) : 128'(0));
            check("gnt0", 128'(gnt0), 128'((m_active || m_done) && !m_port));
            check("gnt1", 128'(gnt1), 128'((m_active || m_done) && m_port));
            check("gnt_exclusive", 128'(gnt0 & gnt1), 128'(0));
            check("done0", 128'(done0), 128'(m_done && !m_port));
            check("done1", 128'(done1), 128'(m_done && m_port));
            if (m_rvalid) check("rdata", 128'(rdata), 128'(exp_line));
        end
    end

    // Runs from the request cycle (cycle 0) until every listed port has seen done.
    task automatic xfer(input bit w0, input bit w1, input bit stall, output int c0, output int c1);
        bit p0, p1;
        p0 = w0; p1 = w1; c0 = -1; c1 = -1;
        for (int cyc = 1; cyc <= 40 && (p0 || p1); cyc++) begin
            @(negedge clk);
            addr_log[cyc] = mem_addr;
            if (stall && cyc == 3) mem_valid = 1'b0;
            if (stall && cyc == 6) mem_valid = 1'b1;
            if (done0) begin c0 = cyc; req0 = 1'b0; p0 = 0; end
            if (done1) begin c1 = cyc; req1 = 1'b0; p1 = 0; end
        end
        if (p0 || p1) check("xfer_timeout", 128'({p0, p1}), 128'(0));
        @(negedge clk);
    endtask

    int c0, c1;

    initial begin
        rst = 1; req0 = 0; req1 = 0; we0 = 0; we1 = 0;
        addr0 = '0; addr1 = '0; wdata0 = '0; wdata1 = '0; mem_valid = 1;
        for (int i = 0; i < 256; i++) mem[i] <= 32'hC000_0000 | 32'(i);
        for (int i = 0; i < 4; i++) mem[32'h40 + i] <= 32'hA0 + 32'(i);
        @(negedge clk);
        rst = 0;
        chk_en = 1;
        check("reset_gnt", 128'({gnt0, gnt1, done0, done1}), 128'(0));
        check("reset_mem", 128'({mem_req_valid, mem_rw, mem_addr, mem_dataW}), 128'(0));
        check("reset_rdata", 128'(rdata), 128'(0));

        // Lone refill on port 0.
        req0 = 1; addr0 = 32'h40; we0 = 0;
        xfer(1, 0, 0, c0, c1);
        check("refill_done_cycle", 128'(c0), 128'(5));
        check("refill_first_addr", 128'(addr_log[1]), 128'h40);
        check("refill_last_addr", 128'(addr_log[4]), 128'h43);
        check("refill_rdata", 128'(rdata), 128'h000000A3_000000A2_000000A1_000000A0);

        // Writeback on port 1 with an unaligned base.
        req1 = 1; addr1 = 32'h12; we1 = 1;
        wdata1 = {32'h14, 32'h13, 32'h12, 32'h11};
        xfer(0, 1, 0, c0, c1);
        check("wb_done_cycle", 128'(c1), 128'(5));
        check("wb_mem", 128'({mem[8'h13], mem[8'h12], mem[8'h11], mem[8'h10]}),
              128'h00000014_00000013_00000012_00000011);
        check("wb_untouched", 128'(mem[8'h14]), 128'hC000_0014);

        // Memory stalls three cycles on beat 2.
        req0 = 1; addr0 = 32'h44; we0 = 0;
        xfer(1, 0, 1, c0, c1);
        check("stall_done_cycle", 128'(c0), 128'(8));
        check("stall_addr_held", 128'({addr_log[3], addr_log[5]}), {64'h0, 32'h46, 32'h46});
        check("stall_rdata", 128'(rdata), 128'hC0000047_C0000046_C0000045_C0000044);

        // Reset during beat 1 aborts the transfer.
        req0 = 1; addr0 = 32'h40; we0 = 0;
        @(negedge clk);
        @(negedge clk);
        check("abort_beat1_addr", 128'(mem_addr), 128'h41);
        rst = 1; req0 = 0;
        @(negedge clk);
        rst = 0;
        check("abort_outputs", 128'({mem_req_valid, gnt0, gnt1, done0, done1, mem_addr}), 128'(0));
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            check("abort_no_done", 128'({done0, done1}), 128'(0));
        end
        req0 = 1; addr0 = 32'h40; we0 = 0;
        xfer(1, 0, 0, c0, c1);
        check("after_abort_done", 128'(c0), 128'(5));
        check("after_abort_rdata", 128'(rdata), 128'h000000A3_000000A2_000000A1_000000A0);

        // Fresh reset then a tie: port 0 wins first.
        rst = 1;
        @(negedge clk);
        rst = 0;
        req0 = 1; addr0 = 32'h40; we0 = 0;
        req1 = 1; addr1 = 32'h20; we1 = 1;
        wdata1 = {32'hB3, 32'hB2, 32'hB1, 32'hB0};
        xfer(1, 1, 0, c0, c1);
        check("tie_port0_first", 128'(c0), 128'(5));
        check("tie_port1_second", 128'(c1), 128'(11));
        check("tie_wb_mem", 128'({mem[8'h23], mem[8'h20]}), 128'h000000B3_000000B0);

        // After a port-0 transfer a tie goes to port 1.
        req0 = 1; addr0 = 32'h44; we0 = 0;
        xfer(1, 0, 0, c0, c1);
        check("lone_port0", 128'(c0), 128'(5));
        req0 = 1; addr0 = 32'h40; we0 = 0;
        req1 = 1; addr1 = 32'h24; we1 = 1;
        wdata1 = {32'hD3, 32'hD2, 32'hD1, 32'hD0};
        xfer(1, 1, 0, c0, c1);
        check("rr_port1_first", 128'(c1), 128'(5));
        check("rr_port0_second", 128'(c0), 128'(11));
        check("rr_rdata", 128'(rdata), 128'h000000A3_000000A2_000000A1_000000A0);

        chk_en = 0;
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
